// File: rtl/booth_mult_param.sv
// Radix-2 Booth sequential multiplier with its own control FSM.
// Operands are widened by one bit on load, so a single signed Booth engine
// handles both unsigned and two's complement products.
module booth_mult_param #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             con_signo,
  input  logic [N-1:0]     multiplicando,
  input  logic [N-1:0]     multiplicador,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   resultado
);

  localparam int W  = N + 1;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {IDLE, OP, SHIFT, DONE} state_t;

  state_t state, state_next;

  logic [W-1:0]  a, m, q;
  logic          q1;
  logic [CW-1:0] count;

  logic [W-1:0]  m_ext, q_ext;
  logic [W-1:0]  m_neg;
  logic [W-1:0]  a_op;
  logic [W-1:0]  a_sh, q_sh;
  logic          q1_sh;

  // Widen operands: sign bit in signed mode, zero in unsigned mode.
  assign m_ext = {con_signo & multiplicando[N-1], multiplicando};
  assign q_ext = {con_signo & multiplicador[N-1], multiplicador};

  // Two's complement of M for the subtract step; carry-out is dropped.
  assign m_neg = ~m + W'(1);

  // Arithmetic right shift of {A, Q, Q-1}, replicating the sign of A.
  assign {a_sh, q_sh, q1_sh} = {a[W-1], a, q};

  // Booth recoding of the current multiplier bit pair.
  always_comb begin
    a_op = a;
    unique case ({q[0], q1})
      2'b01:   a_op = a + m;
      2'b10:   a_op = a + m_neg;
      default: a_op = a;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: one OP/SHIFT pair per widened operand bit.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    state_next = start ? OP : IDLE;
      OP:      state_next = SHIFT;
      SHIFT:   state_next = (count == CW'(1)) ? DONE : OP;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs decoded straight from the state register.
  always_comb begin
    busy = (state == OP) || (state == SHIFT);
    done = (state == DONE);
  end

  // Datapath: load in IDLE, add/subtract in OP, shift and count in SHIFT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a         <= '0;
      m         <= '0;
      q         <= '0;
      q1        <= 1'b0;
      count     <= '0;
      resultado <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a     <= '0;
            m     <= m_ext;
            q     <= q_ext;
            q1    <= 1'b0;
            count <= CW'(W);
          end
        end
        OP: begin
          a <= a_op;
        end
        SHIFT: begin
          a     <= a_sh;
          q     <= q_sh;
          q1    <= q1_sh;
          count <= count - CW'(1);
          if (count == CW'(1))
            resultado <= {a_sh[N-2:0], q_sh};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_param.sv
// Self-checking bench for booth_mult_param: N=8 and N=3 instances checked
// against an integer-arithmetic reference product.
module tb_booth_mult_param;

  logic clk;
  logic reset;

  logic        start8, con_signo8, busy8, done8;
  logic [7:0]  multiplicando8, multiplicador8;
  logic [15:0] resultado8;

  logic        start3, con_signo3, busy3, done3;
  logic [2:0]  multiplicando3, multiplicador3;
  logic [5:0]  resultado3;

  int tests_run;
  int tests_failed;

  booth_mult_param #(.N(8)) dut8 (
    .clk           (clk),
    .reset         (reset),
    .start         (start8),
    .con_signo     (con_signo8),
    .multiplicando (multiplicando8),
    .multiplicador (multiplicador8),
    .busy          (busy8),
    .done          (done8),
    .resultado     (resultado8)
  );

  booth_mult_param #(.N(3)) dut3 (
    .clk           (clk),
    .reset         (reset),
    .start         (start3),
    .con_signo     (con_signo3),
    .multiplicando (multiplicando3),
    .multiplicador (multiplicador3),
    .busy          (busy3),
    .done          (done3),
    .resultado     (resultado3)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference products from plain integer arithmetic.
  function automatic logic [15:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic s);
    int xi, yi, p;
    xi = (s && x[7]) ? int'(x) - 256 : int'(x);
    yi = (s && y[7]) ? int'(y) - 256 : int'(y);
    p  = xi * yi;
    return p[15:0];
  endfunction

  function automatic logic [5:0] ref3(input logic [2:0] x, input logic [2:0] y, input logic s);
    int xi, yi, p;
    xi = (s && x[2]) ? int'(x) - 8 : int'(x);
    yi = (s && y[2]) ? int'(y) - 8 : int'(y);
    p  = xi * yi;
    return p[5:0];
  endfunction

  // Drive one N=8 request, scramble inputs while busy, report what was seen.
  task automatic run_op8(input logic [7:0] x, input logic [7:0] y, input logic s,
                         output logic [15:0] r, output int lat, output int busy_n,
                         output logic held, output logic extra_done);
    logic [15:0] prev;
    @(negedge clk);
    multiplicando8 = x;
    multiplicador8 = y;
    con_signo8     = s;
    start8         = 1'b1;
    prev           = resultado8;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    lat    = -1;
    busy_n = 0;
    held   = 1'b1;
    if (busy8) busy_n++;
    for (int k = 1; k <= 60; k++) begin
      multiplicando8 = 8'($urandom);
      multiplicador8 = 8'($urandom);
      con_signo8     = 1'($urandom);
      start8         = 1'($urandom);
      @(posedge clk);
      #1;
      if (busy8 && resultado8 !== prev) held = 1'b0;
      if (busy8) busy_n++;
      if (done8) begin
        lat = k;
        break;
      end
    end
    start8 = 1'b0;
    r = resultado8;
    @(posedge clk);
    #1;
    extra_done = done8;
  endtask

  // Drive one N=3 request and report the result and its latency.
  task automatic run_op3(input logic [2:0] x, input logic [2:0] y, input logic s,
                         output logic [5:0] r, output int lat);
    @(negedge clk);
    multiplicando3 = x;
    multiplicador3 = y;
    con_signo3     = s;
    start3         = 1'b1;
    @(posedge clk);
    #1;
    start3 = 1'b0;
    lat    = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      #1;
      if (done3) begin
        lat = k;
        break;
      end
    end
    r = resultado3;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || resultado8 !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset8: busy=%b done=%b res=%h, want 0 0 0000", busy8, done8, resultado8);
    end
    tests_run++;
    if (busy3 !== 1'b0 || done3 !== 1'b0 || resultado3 !== 6'h00) begin
      tests_failed++;
      $display("[TB] FAIL reset3: busy=%b done=%b res=%h, want 0 0 00", busy3, done3, resultado3);
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_signed_basic();
    logic [15:0] r;
    int lat, bn;
    logic held, extra;
    run_op8(8'hF9, 8'h05, 1'b1, r, lat, bn, held, extra);
    tests_run++;
    if (r !== 16'hFFDD) begin
      tests_failed++;
      $display("[TB] FAIL signed_basic result: got %h want ffdd", r);
    end
    tests_run++;
    if (lat !== 18) begin
      tests_failed++;
      $display("[TB] FAIL signed_basic latency: got %0d want 18", lat);
    end
    tests_run++;
    if (bn !== 18) begin
      tests_failed++;
      $display("[TB] FAIL signed_basic busy cycles: got %0d want 18", bn);
    end
    tests_run++;
    if (held !== 1'b1 || extra !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL signed_basic hold/pulse: held=%b extra_done=%b want 1 0", held, extra);
    end
  endtask

  task automatic test_extremes();
    logic [7:0]  xa [4] = '{8'hFF, 8'hFF, 8'h80, 8'h80};
    logic [7:0]  ya [4] = '{8'hFF, 8'hFF, 8'h80, 8'h7F};
    logic        sa [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [15:0] ea [4] = '{16'hFE01, 16'h0001, 16'h4000, 16'hC080};
    logic [15:0] r;
    int lat, bn;
    logic held, extra;
    for (int i = 0; i < 4; i++) begin
      run_op8(xa[i], ya[i], sa[i], r, lat, bn, held, extra);
      tests_run++;
      if (r !== ea[i] || lat !== 18) begin
        tests_failed++;
        $display("[TB] FAIL extremes %h*%h s=%b: got %h lat %0d want %h lat 18",
                 xa[i], ya[i], sa[i], r, lat, ea[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0]  x, y;
    logic        s;
    logic [15:0] r;
    int lat, bn;
    logic held, extra;
    for (int i = 0; i < 40; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      s = 1'($urandom);
      run_op8(x, y, s, r, lat, bn, held, extra);
      tests_run++;
      if (r !== ref8(x, y, s) || lat !== 18 || held !== 1'b1 || extra !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL random %h*%h s=%b: got %h lat %0d held %b extra %b want %h lat 18 held 1 extra 0",
                 x, y, s, r, lat, held, extra, ref8(x, y, s));
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_at [$];
    logic res_ok;
    @(negedge clk);
    multiplicando8 = 8'd3;
    multiplicador8 = 8'd4;
    con_signo8     = 1'b0;
    start8         = 1'b1;
    @(posedge clk);
    #1;
    res_ok = 1'b1;
    for (int k = 1; k <= 58; k++) begin
      @(posedge clk);
      #1;
      if (done8) begin
        done_at.push_back(k);
        if (resultado8 !== 16'h000C) res_ok = 1'b0;
      end
    end
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (done_at.size() !== 3 || done_at[0] !== 18 || done_at[1] !== 38 || done_at[2] !== 58) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back done edges: got %p want '{18, 38, 58}", done_at);
    end
    tests_run++;
    if (res_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back result: got %h want 000c", resultado8);
    end
    tests_run++;
    if (busy8 !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL back_to_back idle after release: busy=%b want 0", busy8);
    end
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] r;
    int lat, bn;
    logic held, extra;
    logic saw_done;
    @(negedge clk);
    multiplicando8 = 8'd100;
    multiplicador8 = 8'd100;
    con_signo8     = 1'b0;
    start8         = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    tests_run++;
    if (busy8 !== 1'b1 || resultado8 !== 16'h000C) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid pre: busy=%b res=%h want 1 000c", busy8, resultado8);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy8 !== 1'b0 || done8 !== 1'b0 || resultado8 !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid async clear: busy=%b done=%b res=%h want 0 0 0000",
               busy8, done8, resultado8);
    end
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done8 || busy8) saw_done = 1'b1;
    end
    tests_run++;
    if (saw_done !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid aborted op resumed: activity=%b want 0", saw_done);
    end
    run_op8(8'd2, 8'd3, 1'b0, r, lat, bn, held, extra);
    tests_run++;
    if (r !== 16'h0006 || lat !== 18) begin
      tests_failed++;
      $display("[TB] FAIL reset_mid follow-up: got %h lat %0d want 0006 lat 18", r, lat);
    end
  endtask

  task automatic test_n3();
    logic [5:0] r;
    int lat;
    run_op3(3'b100, 3'b011, 1'b1, r, lat);
    tests_run++;
    if (r !== 6'b110100 || lat !== 8) begin
      tests_failed++;
      $display("[TB] FAIL n3 signed: got %b lat %0d want 110100 lat 8", r, lat);
    end
    run_op3(3'b111, 3'b111, 1'b0, r, lat);
    tests_run++;
    if (r !== 6'b110001 || lat !== 8) begin
      tests_failed++;
      $display("[TB] FAIL n3 unsigned: got %b lat %0d want 110001 lat 8", r, lat);
    end
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 8; x++) begin
        for (int y = 0; y < 8; y++) begin
          run_op3(3'(x), 3'(y), 1'(s), r, lat);
          tests_run++;
          if (r !== ref3(3'(x), 3'(y), 1'(s)) || lat !== 8) begin
            tests_failed++;
            $display("[TB] FAIL n3 sweep %0d*%0d s=%0d: got %b lat %0d want %b lat 8",
                     x, y, s, r, lat, ref3(3'(x), 3'(y), 1'(s)));
          end
        end
      end
    end
  endtask

  // Test sequence.
  initial begin
    tests_run      = 0;
    tests_failed   = 0;
    reset          = 1'b0;
    start8         = 1'b0;
    con_signo8     = 1'b0;
    multiplicando8 = '0;
    multiplicador8 = '0;
    start3         = 1'b0;
    con_signo3     = 1'b0;
    multiplicando3 = '0;
    multiplicador3 = '0;

    test_reset();
    test_signed_basic();
    test_extremes();
    test_random();
    test_back_to_back();
    test_reset_mid_op();
    test_n3();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
